// File: rtl/motor_drive_ramp.sv
// Multi-channel signed-power H-bridge driver: per-channel slew-limited duty,
// direction latching and dead-time on reversal, sharing one PWM period counter.
module motor_drive_ramp #(
    parameter int NUM_CH    = 2,
    parameter int SIZE      = 16,
    parameter int PWM_RES   = 10,
    parameter int PERIOD    = 2000,
    parameter int OFFSET    = 400,
    parameter int RAMP_STEP = 8,
    parameter int DEAD_PER  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_CH*SIZE-1:0]    power,
    output logic [NUM_CH*2-1:0]       dir,
    output logic [NUM_CH-1:0]         pwm,
    output logic [NUM_CH*PWM_RES-1:0] duty_mon,
    output logic                      period_tick
);

    localparam int CW     = $clog2(PERIOD);
    localparam int MW     = PWM_RES + CW;
    localparam int DW     = (DEAD_PER > 1) ? $clog2(DEAD_PER) : 1;
    localparam int DMAX_I = 2 ** PWM_RES - 1;
    localparam logic [SIZE-1:0] SMAX = {1'b0, {(SIZE - 1) {1'b1}}};
    localparam logic [PWM_RES-1:0] DMAX = '1;
    localparam logic [PWM_RES-1:0] RS = PWM_RES'(RAMP_STEP);
    localparam logic [1:0] D_STOP = 2'b00;
    localparam logic [1:0] D_FWD  = 2'b01;
    localparam logic [1:0] D_BWD  = 2'b10;

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_DEAD
    } state_t;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;

    assign tick        = (cnt_q == CW'(PERIOD - 1));
    assign period_tick = tick;

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [SIZE-1:0]    p;
        logic [SIZE-1:0]    neg;
        logic [SIZE-1:0]    mag;
        logic [SIZE:0]      sum;
        logic [1:0]         sdir;
        logic [PWM_RES-1:0] tgt;
        logic [PWM_RES-1:0] eff;
        logic [PWM_RES-1:0] diff;
        logic [PWM_RES-1:0] step;
        logic [PWM_RES-1:0] nxt;
        logic [PWM_RES-1:0] start;
        logic               flip;
        logic [MW-1:0]      prod;

        state_t             state_q, state_d;
        logic [PWM_RES-1:0] duty_q, duty_d;
        logic [1:0]         dir_q, dir_d;
        logic [DW-1:0]      dead_q, dead_d;
        logic [CW-1:0]      thr_q, thr_d;
        logic               pwm_q, pwm_d;

        assign p = power[i*SIZE +: SIZE];

        // Only the most-negative code has its negation overflow into the sign bit.
        always_comb begin
            neg  = ~p + 1'b1;
            sdir = D_STOP;
            mag  = '0;
            if (p != '0) begin
                if (p[SIZE-1]) begin
                    sdir = D_FWD;
                    mag  = neg[SIZE-1] ? SMAX : neg;
                end else begin
                    sdir = D_BWD;
                    mag  = p;
                end
            end
            sum = {1'b0, mag} + (SIZE + 1)'(OFFSET);
            tgt = '0;
            if (sdir != D_STOP) begin
                if (sum > (SIZE + 1)'(DMAX_I)) tgt = DMAX;
                else                           tgt = sum[PWM_RES-1:0];
            end
        end

        always_comb begin
            flip  = (tgt != '0) && (sdir != dir_q);
            eff   = (flip || tgt == '0) ? '0 : tgt;
            diff  = (eff > duty_q) ? eff - duty_q : duty_q - eff;
            step  = (diff > RS) ? RS : diff;
            nxt   = (eff > duty_q) ? duty_q + step : duty_q - step;
            start = (tgt > RS) ? RS : tgt;
        end

        always_comb begin
            state_d = state_q;
            duty_d  = duty_q;
            dir_d   = dir_q;
            dead_d  = dead_q;
            if (!en) begin
                state_d = ST_STOP;
                duty_d  = '0;
                dir_d   = D_STOP;
                dead_d  = '0;
            end else if (tick) begin
                unique case (state_q)
                    ST_STOP: begin
                        duty_d = '0;
                        dir_d  = D_STOP;
                        if (tgt != '0) begin
                            state_d = ST_RUN;
                            dir_d   = sdir;
                            duty_d  = start;
                        end
                    end
                    ST_RUN: begin
                        duty_d = nxt;
                        if (nxt == '0) begin
                            state_d = flip ? ST_DEAD : ST_STOP;
                            dir_d   = D_STOP;
                            dead_d  = '0;
                        end
                    end
                    ST_DEAD: begin
                        duty_d = '0;
                        dir_d  = D_STOP;
                        if (dead_q == DW'(DEAD_PER - 1)) begin
                            dead_d  = '0;
                            state_d = ST_STOP;
                            if (tgt != '0) begin
                                state_d = ST_RUN;
                                dir_d   = sdir;
                                duty_d  = start;
                            end
                        end else begin
                            dead_d = dead_q + 1'b1;
                        end
                    end
                    default: state_d = ST_STOP;
                endcase
            end
        end

        // Threshold tracks the duty chosen on this tick so the whole period uses it.
        always_comb begin
            prod  = MW'(duty_d) * MW'(PERIOD);
            thr_d = thr_q;
            if (!en)       thr_d = '0;
            else if (tick) thr_d = prod[MW-1:PWM_RES];
            pwm_d = en && (cnt_q < thr_q);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_STOP;
                duty_q  <= '0;
                dir_q   <= D_STOP;
                dead_q  <= '0;
                thr_q   <= '0;
                pwm_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                duty_q  <= duty_d;
                dir_q   <= dir_d;
                dead_q  <= dead_d;
                thr_q   <= thr_d;
                pwm_q   <= pwm_d;
            end
        end

        assign dir[2*i +: 2]                = dir_q;
        assign pwm[i]                       = pwm_q;
        assign duty_mon[i*PWM_RES +: PWM_RES] = duty_q;
    end

endmodule

// File: tb/tb_motor_drive_ramp.sv
// Directed bench for motor_drive_ramp, run with a 100-cycle PWM period
// so full ramps fit in a short simulation.
module tb_motor_drive_ramp;

    localparam int P = 100;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] power;
    logic [3:0]  dir;
    logic [1:0]  pwm;
    logic [19:0] duty_mon;
    logic        period_tick;

    int nchk;
    int nfail;

    motor_drive_ramp #(
        .NUM_CH   (2),
        .SIZE     (16),
        .PWM_RES  (10),
        .PERIOD   (P),
        .OFFSET   (400),
        .RAMP_STEP(8),
        .DEAD_PER (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .power      (power),
        .dir        (dir),
        .pwm        (pwm),
        .duty_mon   (duty_mon),
        .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    // Advance to just past the next tick edge, counting pwm high cycles on the way.
    task automatic goto_tick(output int h0, output int h1);
        int n;
        h0 = 0;
        h1 = 0;
        n  = 0;
        do begin
            @(negedge clk);
            h0 += int'(pwm[0]);
            h1 += int'(pwm[1]);
            n++;
        end while (!period_tick && n < 2 * P);
        if (!period_tick) begin
            nchk++;
            nfail++;
            $display("FAIL tick_timeout waited %0d cycles, required tick within %0d", n, P);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        en    = 1'b1;
        power = '0;
        #1;
        nchk++;
        if (dir !== 4'b0000) begin
            nfail++;
            $display("FAIL reset_dir got %b exp 0000", dir);
        end
        nchk++;
        if (pwm !== 2'b00) begin
            nfail++;
            $display("FAIL reset_pwm got %b exp 00", pwm);
        end
        nchk++;
        if (duty_mon !== 20'd0) begin
            nfail++;
            $display("FAIL reset_duty got %h exp 0", duty_mon);
        end
        nchk++;
        if (period_tick !== 1'b0) begin
            nfail++;
            $display("FAIL reset_tick got %b exp 0", period_tick);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ramp_up();
        int h0, h1, exp;
        power = {16'd0, 16'd100};
        goto_tick(h0, h1);
        nchk++;
        if (dir !== 4'b0010 || duty_mon !== {10'd0, 10'd8}) begin
            nfail++;
            $display("FAIL ramp_first_tick dir=%b duty=%h exp dir=0010 duty0=8 duty1=0",
                     dir, duty_mon);
        end
        for (int k = 2; k <= 63; k++) begin
            goto_tick(h0, h1);
            exp = (8 * k > 500) ? 500 : 8 * k;
            nchk++;
            if (int'(duty_mon[9:0]) != exp) begin
                nfail++;
                $display("FAIL ramp_duty k=%0d got %0d exp %0d", k, duty_mon[9:0], exp);
            end
        end
        goto_tick(h0, h1);
        nchk++;
        if (h0 != 48 || h1 != 0 || dir !== 4'b0010) begin
            nfail++;
            $display("FAIL ramp_pwm_width got h0=%0d h1=%0d dir=%b exp 48 0 0010", h0, h1, dir);
        end
    endtask

    task automatic test_mid_period_change();
        int  n;
        logic ok;
        repeat (35) @(posedge clk);
        #1;
        power[31:16] = 16'hFFCE;
        ok = 1'b1;
        n  = 0;
        do begin
            @(negedge clk);
            if (dir !== 4'b0010 || pwm[1] !== 1'b0 || duty_mon !== {10'd0, 10'd500})
                ok = 1'b0;
            n++;
        end while (!period_tick && n < 2 * P);
        nchk++;
        if (!ok || !period_tick) begin
            nfail++;
            $display("FAIL mid_period_hold changed before tick ok=%b tick=%b exp 1 1",
                     ok, period_tick);
        end
        @(posedge clk);
        #1;
        nchk++;
        if (dir !== 4'b0110 || duty_mon !== {10'd8, 10'd500}) begin
            nfail++;
            $display("FAIL mid_period_tick dir=%b duty=%h exp dir=0110 duty1=8 duty0=500",
                     dir, duty_mon);
        end
    endtask

    task automatic test_reversal();
        int h0, h1, exp;
        logic [1:0] edir;
        power = {16'd0, 16'hFF9C};
        for (int k = 1; k <= 63; k++) begin
            goto_tick(h0, h1);
            exp  = (500 - 8 * k < 0) ? 0 : 500 - 8 * k;
            edir = (k < 63) ? 2'b10 : 2'b00;
            nchk++;
            if (int'(duty_mon[9:0]) != exp || dir[1:0] !== edir) begin
                nfail++;
                $display("FAIL rev_down k=%0d duty=%0d dir=%b exp %0d %b",
                         k, duty_mon[9:0], dir[1:0], exp, edir);
            end
            if (k == 1) begin
                nchk++;
                if (dir[3:2] !== 2'b00 || duty_mon[19:10] !== 10'd0) begin
                    nfail++;
                    $display("FAIL rev_ch1_stop dir=%b duty=%0d exp 00 0",
                             dir[3:2], duty_mon[19:10]);
                end
            end
        end
        goto_tick(h0, h1);
        nchk++;
        if (h0 != 0 || dir[1:0] !== 2'b00) begin
            nfail++;
            $display("FAIL rev_dead_pwm h0=%0d dir=%b exp 0 00", h0, dir[1:0]);
        end
        for (int k = 65; k <= 66; k++) begin
            goto_tick(h0, h1);
            nchk++;
            if (dir[1:0] !== 2'b00 || duty_mon[9:0] !== 10'd0 || h0 != 0) begin
                nfail++;
                $display("FAIL rev_dead k=%0d dir=%b duty=%0d h0=%0d exp 00 0 0",
                         k, dir[1:0], duty_mon[9:0], h0);
            end
        end
        goto_tick(h0, h1);
        nchk++;
        if (dir[1:0] !== 2'b01 || duty_mon[9:0] !== 10'd8) begin
            nfail++;
            $display("FAIL rev_restart dir=%b duty=%0d exp 01 8", dir[1:0], duty_mon[9:0]);
        end
    endtask

    task automatic test_saturation();
        int h0, h1, e0, e1;
        power = {16'h7FFF, 16'h8000};
        for (int k = 1; k <= 128; k++) begin
            goto_tick(h0, h1);
            e0 = (8 + 8 * k > 1023) ? 1023 : 8 + 8 * k;
            e1 = (8 * k > 1023) ? 1023 : 8 * k;
            nchk++;
            if (int'(duty_mon[9:0]) != e0 || int'(duty_mon[19:10]) != e1) begin
                nfail++;
                $display("FAIL sat_ramp k=%0d d0=%0d d1=%0d exp %0d %0d",
                         k, duty_mon[9:0], duty_mon[19:10], e0, e1);
            end
        end
        goto_tick(h0, h1);
        nchk++;
        if (h0 != 99 || h1 != 99 || dir !== 4'b1001) begin
            nfail++;
            $display("FAIL sat_full h0=%0d h1=%0d dir=%b exp 99 99 1001", h0, h1, dir);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        repeat (30) @(posedge clk);
        #3;
        nchk++;
        if (pwm !== 2'b11) begin
            nfail++;
            $display("FAIL rstmid_pre_pwm got %b exp 11", pwm);
        end
        rst = 1'b1;
        #1;
        nchk++;
        if (dir !== 4'b0000 || pwm !== 2'b00 || duty_mon !== 20'd0 || period_tick !== 1'b0) begin
            nfail++;
            $display("FAIL rstmid_outputs dir=%b pwm=%b duty=%h tick=%b exp all 0",
                     dir, pwm, duty_mon, period_tick);
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < 2 * P);
        nchk++;
        if (n != P - 1) begin
            nfail++;
            $display("FAIL rstmid_counter cycles_to_tick got %0d exp %0d", n, P - 1);
        end
        @(posedge clk);
        #1;
        nchk++;
        if (dir !== 4'b1001 || duty_mon !== {10'd8, 10'd8}) begin
            nfail++;
            $display("FAIL rstmid_restart dir=%b duty=%h exp 1001 d0=8 d1=8", dir, duty_mon);
        end
    endtask

    task automatic test_enable();
        int h0, h1;
        goto_tick(h0, h1);
        nchk++;
        if (duty_mon !== {10'd16, 10'd16}) begin
            nfail++;
            $display("FAIL en_pre_duty got %h exp d0=16 d1=16", duty_mon);
        end
        repeat (40) @(posedge clk);
        #1;
        en = 1'b0;
        @(posedge clk);
        #1;
        en = 1'b1;
        nchk++;
        if (duty_mon !== 20'd0 || pwm !== 2'b00 || dir !== 4'b0000) begin
            nfail++;
            $display("FAIL en_drop duty=%h pwm=%b dir=%b exp 0 00 0000", duty_mon, pwm, dir);
        end
        goto_tick(h0, h1);
        nchk++;
        if (h0 != 0 || h1 != 0) begin
            nfail++;
            $display("FAIL en_rest_pwm h0=%0d h1=%0d exp 0 0", h0, h1);
        end
        nchk++;
        if (dir !== 4'b1001 || duty_mon !== {10'd8, 10'd8}) begin
            nfail++;
            $display("FAIL en_restart dir=%b duty=%h exp 1001 d0=8 d1=8", dir, duty_mon);
        end
    endtask

    initial begin
        clk   = 1'b0;
        rst   = 1'b1;
        en    = 1'b1;
        power = '0;
        nchk  = 0;
        nfail = 0;
        test_reset();
        test_ramp_up();
        test_mid_period_change();
        test_reversal();
        test_saturation();
        test_reset_mid();
        test_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
